// File: rtl/uart_controller_if.sv
// Host-side byte interface of uart_controller: a request/acknowledge pair for
// writing bytes to transmit and a request/acknowledge pair for reading received bytes.
interface uart_controller_if;
   logic [7:0] uart_in_data;
   logic       uart_in_valid;
   logic       uart_in_ready;
   logic       uart_out_valid;
   logic [7:0] uart_out_data;
   logic       uart_out_ready;

   modport master (
      output uart_in_data,
      output uart_in_valid,
      output uart_out_valid,
      input  uart_in_ready,
      input  uart_out_data,
      input  uart_out_ready
   );

   modport slave (
      input  uart_in_data,
      input  uart_in_valid,
      input  uart_out_valid,
      output uart_in_ready,
      output uart_out_data,
      output uart_out_ready
   );
endinterface

// File: rtl/uart_controller.sv
// Buffers bytes between a UART core and a host using one RX and one TX circular FIFO.
// Optional macro UART_CONTROLLER_LOST_EN makes 'lost' a sticky RX-overflow flag (else tied 0).
module uart_controller #(
   parameter int LEN_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   uart_controller_if.slave     host,
   output logic                 recv_reset,
   input  logic [7:0]           recv_data,
   input  logic                 recv_ok,
   output logic                 trans_reset,
   output logic [7:0]           trans_data,
   output logic                 trans_ok,
   input  logic                 trans_busy,
   output logic [LEN_WIDTH-1:0] in_buffer_length,
   output logic [LEN_WIDTH-1:0] out_buffer_length,
   output logic                 lost
);

   localparam int DEPTH = 1 << LEN_WIDTH;

   logic [7:0]           r_rx_mem [DEPTH];
   logic [LEN_WIDTH-1:0] r_rx_head;
   logic [LEN_WIDTH-1:0] r_rx_tail;
   logic [LEN_WIDTH-1:0] w_rx_head_next;
   logic [LEN_WIDTH-1:0] w_rx_tail_next;
   logic                 w_rx_full;
   logic                 w_rx_empty;
   logic                 w_rx_push;
   logic                 w_rx_pop;

   logic [7:0]           r_tx_mem [DEPTH];
   logic [LEN_WIDTH-1:0] r_tx_head;
   logic [LEN_WIDTH-1:0] r_tx_tail;
   logic [LEN_WIDTH-1:0] w_tx_head_next;
   logic [LEN_WIDTH-1:0] w_tx_tail_next;
   logic                 w_tx_full;
   logic                 w_tx_empty;
   logic                 w_tx_push;
   logic                 w_tx_pop;

   logic                 r_recv_reset;
   logic                 r_trans_reset;
   logic [7:0]           r_out_data;
   logic                 r_out_ready;
   logic                 r_in_ready;
   logic [7:0]           r_trans_data;
   logic                 r_trans_ok;
   logic [LEN_WIDTH-1:0] r_in_len;
   logic [LEN_WIDTH-1:0] r_out_len;

   // Full/empty always come from the current pointers, so a same-cycle pop
   // never makes room for a push and a same-cycle push never feeds a pop.
   assign w_rx_full  = (r_rx_tail + LEN_WIDTH'(1)) == r_rx_head;
   assign w_rx_empty = r_rx_tail == r_rx_head;
   assign w_tx_full  = (r_tx_tail + LEN_WIDTH'(1)) == r_tx_head;
   assign w_tx_empty = r_tx_tail == r_tx_head;

   assign w_rx_push = recv_ok & ~w_rx_full;
   assign w_rx_pop  = host.uart_out_valid & ~w_rx_empty & ~r_out_ready;
   assign w_tx_push = host.uart_in_valid & ~w_tx_full & ~r_in_ready;
   assign w_tx_pop  = ~trans_busy & ~w_tx_empty;

   always_comb begin
      w_rx_head_next = r_rx_head;
      w_rx_tail_next = r_rx_tail;
      w_tx_head_next = r_tx_head;
      w_tx_tail_next = r_tx_tail;
      if (w_rx_push) w_rx_tail_next = r_rx_tail + LEN_WIDTH'(1);
      if (w_rx_pop)  w_rx_head_next = r_rx_head + LEN_WIDTH'(1);
      if (w_tx_push) w_tx_tail_next = r_tx_tail + LEN_WIDTH'(1);
      if (w_tx_pop)  w_tx_head_next = r_tx_head + LEN_WIDTH'(1);
   end

   // Storage arrays carry no reset so they can map onto block RAM.
   always_ff @(posedge clk) begin
      if (w_rx_push) r_rx_mem[r_rx_tail] <= recv_data;
      if (w_tx_push) r_tx_mem[r_tx_tail] <= host.uart_in_data;
   end

   always_ff @(posedge clk) begin
      r_recv_reset  <= reset;
      r_trans_reset <= reset;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_head    <= '0;
         r_rx_tail    <= '0;
         r_tx_head    <= '0;
         r_tx_tail    <= '0;
         r_out_data   <= '0;
         r_out_ready  <= 1'b0;
         r_in_ready   <= 1'b0;
         r_trans_data <= '0;
         r_trans_ok   <= 1'b0;
         r_in_len     <= '0;
         r_out_len    <= '0;
      end else begin
         r_rx_head   <= w_rx_head_next;
         r_rx_tail   <= w_rx_tail_next;
         r_tx_head   <= w_tx_head_next;
         r_tx_tail   <= w_tx_tail_next;
         r_out_ready <= w_rx_pop;
         r_in_ready  <= w_tx_push;
         r_trans_ok  <= w_tx_pop;
         if (w_rx_pop) r_out_data   <= r_rx_mem[r_rx_head];
         if (w_tx_pop) r_trans_data <= r_tx_mem[r_tx_head];
         r_in_len    <= w_tx_tail_next - w_tx_head_next;
         r_out_len   <= w_rx_tail_next - w_rx_head_next;
      end
   end

`ifdef UART_CONTROLLER_LOST_EN
   logic r_lost;
   logic w_rx_drop;

   assign w_rx_drop = recv_ok & w_rx_full;

   always_ff @(posedge clk) begin
      if (reset)          r_lost <= 1'b0;
      else if (w_rx_drop) r_lost <= 1'b1;
   end

   assign lost = r_lost;
`else
   assign lost = 1'b0;
`endif

   assign recv_reset          = r_recv_reset;
   assign trans_reset         = r_trans_reset;
   assign trans_data          = r_trans_data;
   assign trans_ok            = r_trans_ok;
   assign in_buffer_length    = r_in_len;
   assign out_buffer_length   = r_out_len;
   assign host.uart_out_data  = r_out_data;
   assign host.uart_out_ready = r_out_ready;
   assign host.uart_in_ready  = r_in_ready;

endmodule

// File: tb/tb_uart_controller.sv
// Scoreboard bench for uart_controller (LEN_WIDTH=3): directed vectors push expected
// bytes into queues; a negedge monitor pops and compares on every RX/TX acknowledge.
module tb_uart_controller;
   localparam int LW = 3;
`ifdef UART_CONTROLLER_LOST_EN
   localparam int LOST_EXP = 1;
`else
   localparam int LOST_EXP = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          recv_reset;
   logic [7:0]    recv_data;
   logic          recv_ok;
   logic          trans_reset;
   logic [7:0]    trans_data;
   logic          trans_ok;
   logic          trans_busy;
   logic [LW-1:0] in_buffer_length;
   logic [LW-1:0] out_buffer_length;
   logic          lost;

   uart_controller_if u_if ();

   uart_controller #(.LEN_WIDTH(LW)) dut (
      .clk               (clk),
      .reset             (reset),
      .host              (u_if),
      .recv_reset        (recv_reset),
      .recv_data         (recv_data),
      .recv_ok           (recv_ok),
      .trans_reset       (trans_reset),
      .trans_data        (trans_data),
      .trans_ok          (trans_ok),
      .trans_busy        (trans_busy),
      .in_buffer_length  (in_buffer_length),
      .out_buffer_length (out_buffer_length),
      .lost              (lost)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] rx_exp [$];
   logic [7:0] tx_exp [$];
   logic [7:0] rx_e;
   logic [7:0] tx_e;

   logic [7:0] rxv [6] = '{8'h81, 8'h42, 8'hC3, 8'h24, 8'hE5, 8'h66};
   logic [7:0] txv [3] = '{8'h17, 8'h28, 8'h39};
   logic [7:0] fillv [7] = '{8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
   logic [7:0] t4v [4] = '{8'h5A, 8'hA5, 8'hE3, 8'h1C};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: every acknowledge on either side consumes one expected byte.
   always @(negedge clk) begin
      if (u_if.uart_out_ready) begin
         total++;
         if (rx_exp.size() == 0) begin
            bad++;
            $display("FAIL rx_unexpected actual=%02h required=none", u_if.uart_out_data);
         end else begin
            rx_e = rx_exp.pop_front();
            if (u_if.uart_out_data !== rx_e) begin
               bad++;
               $display("FAIL rx_data actual=%02h required=%02h", u_if.uart_out_data, rx_e);
            end else
               $display("rx byte %02h", u_if.uart_out_data);
         end
      end
      if (trans_ok) begin
         total++;
         if (tx_exp.size() == 0) begin
            bad++;
            $display("FAIL tx_unexpected actual=%02h required=none", trans_data);
         end else begin
            tx_e = tx_exp.pop_front();
            if (trans_data !== tx_e) begin
               bad++;
               $display("FAIL tx_data actual=%02h required=%02h", trans_data, tx_e);
            end else
               $display("tx byte %02h", trans_data);
         end
      end
   end

   task automatic recv_byte(input logic [7:0] b);
      recv_data = b;
      recv_ok   = 1'b1;
      tick();
      recv_ok   = 1'b0;
      tick();
   endtask

   task automatic host_write(input logic [7:0] b);
      u_if.uart_in_data  = b;
      u_if.uart_in_valid = 1'b1;
      tick();
      check("in_ready_ack", int'(u_if.uart_in_ready), 1);
      u_if.uart_in_valid = 1'b0;
      tick();
      check("in_ready_drop", int'(u_if.uart_in_ready), 0);
   endtask

   initial begin
      reset               = 1'b1;
      recv_ok             = 1'b0;
      recv_data           = 8'h00;
      trans_busy          = 1'b1;
      u_if.uart_in_data   = 8'h00;
      u_if.uart_in_valid  = 1'b0;
      u_if.uart_out_valid = 1'b0;

      // Reset behaviour
      repeat (5) tick();
      check("recv_reset_hi", int'(recv_reset), 1);
      check("trans_reset_hi", int'(trans_reset), 1);
      check("in_len_rst", int'(in_buffer_length), 0);
      check("out_len_rst", int'(out_buffer_length), 0);
      check("out_ready_rst", int'(u_if.uart_out_ready), 0);
      check("in_ready_rst", int'(u_if.uart_in_ready), 0);
      check("trans_ok_rst", int'(trans_ok), 0);
      check("lost_rst", int'(lost), 0);
      reset = 1'b0;
      tick();
      check("recv_reset_lo", int'(recv_reset), 0);
      check("trans_reset_lo", int'(trans_reset), 0);

      // RX: three bytes, held read gives alternate acks
      rx_exp.push_back(8'hB3); recv_byte(8'hB3);
      rx_exp.push_back(8'h5F); recv_byte(8'h5F);
      rx_exp.push_back(8'hAA); recv_byte(8'hAA);
      check("out_len_3", int'(out_buffer_length), 3);
      u_if.uart_out_valid = 1'b1;
      tick(); check("rd_pat0", int'(u_if.uart_out_ready), 1);
      tick(); check("rd_pat1", int'(u_if.uart_out_ready), 0);
      tick(); check("rd_pat2", int'(u_if.uart_out_ready), 1);
      tick(); check("rd_pat3", int'(u_if.uart_out_ready), 0);
      rx_exp.push_back(8'h0F);
      recv_data = 8'h0F;
      recv_ok   = 1'b1;
      tick();
      recv_ok   = 1'b0;
      repeat (5) tick();
      check("rd_empty0", int'(u_if.uart_out_ready), 0);
      tick();
      check("rd_empty1", int'(u_if.uart_out_ready), 0);
      check("out_len_drained", int'(out_buffer_length), 0);
      check("rx_sb_empty1", rx_exp.size(), 0);
      u_if.uart_out_valid = 1'b0;
      check("lost_before_ovf", int'(lost), 0);

      // RX overflow: 12 pushes into a 7-byte FIFO
      recv_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         recv_data = 8'hB3; rx_exp.push_back(8'hB3); tick();
      end
      for (int i = 0; i < 8; i++) begin
         recv_data = 8'h4C;
         if (i < 3) rx_exp.push_back(8'h4C);
         tick();
      end
      recv_ok = 1'b0;
      check("out_len_full", int'(out_buffer_length), 7);
      check("lost_after_ovf", int'(lost), LOST_EXP);
      u_if.uart_out_valid = 1'b1;
      repeat (16) tick();
      check("ovf_drain_ready", int'(u_if.uart_out_ready), 0);
      u_if.uart_out_valid = 1'b0;
      tick();
      check("out_len_ovf_drained", int'(out_buffer_length), 0);
      check("rx_sb_empty2", rx_exp.size(), 0);
      check("lost_sticky", int'(lost), LOST_EXP);

      // TX: four writes while busy, then a burst
      for (int i = 0; i < 4; i++) begin
         tx_exp.push_back(t4v[i]);
         host_write(t4v[i]);
      end
      check("in_len_4", int'(in_buffer_length), 4);
      trans_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("tx_burst_ok", int'(trans_ok), 1);
      end
      tick();
      check("tx_burst_end", int'(trans_ok), 0);
      check("in_len_burst0", int'(in_buffer_length), 0);
      trans_busy = 1'b1;

      // TX full: backpressure until one byte leaves
      for (int i = 0; i < 7; i++) begin
         tx_exp.push_back(fillv[i]);
         host_write(fillv[i]);
      end
      check("in_len_full", int'(in_buffer_length), 7);
      u_if.uart_in_data  = 8'hFF;
      u_if.uart_in_valid = 1'b1;
      tick(); check("full_stall0", int'(u_if.uart_in_ready), 0);
      tick(); check("full_stall1", int'(u_if.uart_in_ready), 0);
      trans_busy = 1'b0;
      tick();
      check("full_pop_ok", int'(trans_ok), 1);
      check("full_pop_stall", int'(u_if.uart_in_ready), 0);
      trans_busy = 1'b1;
      tx_exp.push_back(8'hFF);
      tick();
      check("full_accept", int'(u_if.uart_in_ready), 1);
      u_if.uart_in_valid = 1'b0;
      tick();
      check("full_accept_drop", int'(u_if.uart_in_ready), 0);
      check("in_len_refill", int'(in_buffer_length), 7);
      trans_busy = 1'b0;
      repeat (8) tick();
      check("tx_full_done", int'(trans_ok), 0);
      check("in_len_full_drained", int'(in_buffer_length), 0);
      check("tx_sb_empty1", tx_exp.size(), 0);

      // Concurrent RX and TX traffic
      u_if.uart_out_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         recv_data = rxv[k];
         recv_ok   = 1'b1;
         rx_exp.push_back(rxv[k]);
         u_if.uart_in_valid = (k % 2 == 0);
         u_if.uart_in_data  = txv[k / 2];
         if (k % 2 == 0) tx_exp.push_back(txv[k / 2]);
         tick();
      end
      recv_ok            = 1'b0;
      u_if.uart_in_valid = 1'b0;
      check("conc_out_len", int'(out_buffer_length), 3);
      check("conc_in_len", int'(in_buffer_length), 0);
      repeat (10) tick();
      check("conc_out_len_end", int'(out_buffer_length), 0);
      check("conc_rx_sb", rx_exp.size(), 0);
      check("conc_tx_sb", tx_exp.size(), 0);
      u_if.uart_out_valid = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
